// File: rtl/uart_transmitter.sv
// UART transmit stage: one-entry holding register feeding a shift register that
// drives start / 8 data LSB-first / optional even parity / stop bit(s) onto the line.
module uart_transmitter #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned STOP_BITS  = 2,
  parameter int unsigned PARITY_EN  = 1
) (
  input  logic       OverSamplingClock,
  input  logic       Reset,
  input  logic [7:0] DataIn,
  input  logic       LoadStrobe,
  input  logic       HostAcknowledge,
  output logic       DataOut,
  output logic       Busy,
  output logic       HoldingFull,
  output logic       HostInterrupt,
  output logic       ErrorOut
);

  localparam int unsigned TICK_W     = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W      = 3;
  localparam bit          HAS_PARITY = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e             state_q;
  logic [TICK_W-1:0]  tick_q;
  logic [IDX_W-1:0]   bit_idx_q;
  logic [7:0]         hold_q;
  logic               hold_full_q;
  logic [7:0]         shift_q;
  logic               parity_q;
  logic               line_q;
  logic               busy_q;
  logic               irq_q;
  logic               error_q;

  logic bit_end;
  logic frame_end;
  logic transfer;

  // Transfer happens from idle, or on the very last stop tick so frames abut.
  assign bit_end   = (tick_q == TICK_W'(OVERSAMPLE - 1));
  assign frame_end = (state_q == S_STOP) && bit_end && (bit_idx_q == IDX_W'(STOP_BITS - 1));
  assign transfer  = hold_full_q && ((state_q == S_IDLE) || frame_end);

  always_ff @(posedge OverSamplingClock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      tick_q      <= '0;
      bit_idx_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      line_q      <= 1'b1;
      busy_q      <= 1'b0;
      irq_q       <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      // A write is accepted when the slot is empty or is being vacated this edge.
      if (LoadStrobe && (!hold_full_q || transfer)) begin
        hold_q      <= DataIn;
        hold_full_q <= 1'b1;
      end else if (transfer) begin
        hold_full_q <= 1'b0;
      end

      if (LoadStrobe && hold_full_q && !transfer) begin
        error_q <= 1'b1;
      end

      if (transfer) begin
        irq_q <= 1'b1;
      end else if (HostAcknowledge) begin
        irq_q <= 1'b0;
      end

      if (transfer) begin
        shift_q   <= hold_q;
        parity_q  <= ^hold_q;
        state_q   <= S_START;
        tick_q    <= '0;
        bit_idx_q <= '0;
        line_q    <= 1'b0;
        busy_q    <= 1'b1;
      end else if (state_q != S_IDLE) begin
        if (!bit_end) begin
          tick_q <= tick_q + TICK_W'(1);
        end else begin
          tick_q <= '0;
          case (state_q)
            S_START: begin
              state_q   <= S_DATA;
              bit_idx_q <= '0;
              line_q    <= shift_q[0];
            end
            S_DATA: begin
              if (bit_idx_q == IDX_W'(7)) begin
                bit_idx_q <= '0;
                if (HAS_PARITY) begin
                  state_q <= S_PARITY;
                  line_q  <= parity_q;
                end else begin
                  state_q <= S_STOP;
                  line_q  <= 1'b1;
                end
              end else begin
                shift_q   <= shift_q >> 1;
                line_q    <= shift_q[1];
                bit_idx_q <= bit_idx_q + IDX_W'(1);
              end
            end
            S_PARITY: begin
              state_q   <= S_STOP;
              bit_idx_q <= '0;
              line_q    <= 1'b1;
            end
            S_STOP: begin
              if (frame_end) begin
                state_q   <= S_IDLE;
                bit_idx_q <= '0;
                busy_q    <= 1'b0;
              end else begin
                bit_idx_q <= bit_idx_q + IDX_W'(1);
              end
              line_q <= 1'b1;
            end
            default: begin
              state_q <= S_IDLE;
              line_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign DataOut       = line_q;
  assign Busy          = busy_q;
  assign HoldingFull   = hold_full_q;
  assign HostInterrupt = irq_q;
  assign ErrorOut      = error_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter with default parameters (16x, 2 stop, even parity).
module tb_uart_transmitter;

  localparam int OS    = 16;
  localparam int FRAME = 192;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] DataIn = 8'h00;
  logic       LoadStrobe = 1'b0;
  logic       HostAcknowledge = 1'b0;
  logic       DataOut, Busy, HoldingFull, HostInterrupt, ErrorOut;

  int n_assert = 0;
  int n_fail   = 0;

  uart_transmitter dut (
    .OverSamplingClock (clk),
    .Reset             (Reset),
    .DataIn            (DataIn),
    .LoadStrobe        (LoadStrobe),
    .HostAcknowledge   (HostAcknowledge),
    .DataOut           (DataOut),
    .Busy              (Busy),
    .HoldingFull       (HoldingFull),
    .HostInterrupt     (HostInterrupt),
    .ErrorOut          (ErrorOut)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected line level t edges after the load edge of a lone frame.
  function automatic logic frame_bit(input logic [7:0] d, input int t);
    int b;
    if (t < 1) return 1'b1;
    b = (t - 1) / OS;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (b == 9) return ^d;
    return 1'b1;
  endfunction

  function automatic logic two_frames(input logic [7:0] d0, input logic [7:0] d1, input int t);
    if (t <= FRAME) return frame_bit(d0, t);
    return frame_bit(d1, t - FRAME);
  endfunction

  initial begin
    // Reset with no clock edge
    #1 Reset = 1'b0;
    #2;
    chk("rst_dataout", DataOut, 1'b1);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_holdfull", HoldingFull, 1'b0);
    chk("rst_irq", HostInterrupt, 1'b0);
    chk("rst_error", ErrorOut, 1'b0);
    step(); step(); step();
    Reset = 1'b1;
    step();

    // Single byte 0xA5
    DataIn = 8'hA5; LoadStrobe = 1'b1;
    step();
    LoadStrobe = 1'b0;
    chk("single_hf_e0", HoldingFull, 1'b1);
    chk("single_busy_e0", Busy, 1'b0);
    chk("single_line_e0", DataOut, 1'b1);
    for (int t = 1; t <= FRAME + 1; t++) begin
      step();
      chk("single_line", DataOut, frame_bit(8'hA5, t));
      if (t == 1) begin
        chk("single_busy_e1", Busy, 1'b1);
        chk("single_hf_e1", HoldingFull, 1'b0);
        chk("single_irq_e1", HostInterrupt, 1'b1);
      end
      if (t == FRAME) chk("single_busy_e192", Busy, 1'b1);
      if (t == FRAME + 1) chk("single_busy_e193", Busy, 1'b0);
    end
    chk("single_irq_held", HostInterrupt, 1'b1);
    HostAcknowledge = 1'b1;
    step();
    HostAcknowledge = 1'b0;
    chk("single_irq_ack", HostInterrupt, 1'b0);
    step();

    // Back-to-back 0x01 then 0x80
    DataIn = 8'h01; LoadStrobe = 1'b1;
    step();
    for (int t = 1; t <= 2 * FRAME + 1; t++) begin
      LoadStrobe = (t == 20);
      DataIn = 8'h80;
      HostAcknowledge = (t == 50);
      step();
      LoadStrobe = 1'b0; HostAcknowledge = 1'b0;
      chk("b2b_line", DataOut, two_frames(8'h01, 8'h80, t));
      if (t == 20) chk("b2b_hf_e20", HoldingFull, 1'b1);
      if (t == 50) chk("b2b_irq_e50", HostInterrupt, 1'b0);
      if (t == FRAME) chk("b2b_irq_e192", HostInterrupt, 1'b0);
      if (t == FRAME + 1) begin
        chk("b2b_irq_e193", HostInterrupt, 1'b1);
        chk("b2b_hf_e193", HoldingFull, 1'b0);
        chk("b2b_busy_e193", Busy, 1'b1);
      end
      if (t == 2 * FRAME + 1) chk("b2b_busy_end", Busy, 1'b0);
    end
    HostAcknowledge = 1'b1;
    step();
    HostAcknowledge = 1'b0;

    // Overrun: 0x11, 0x22, 0x33 at edges 0, 5, 10
    DataIn = 8'h11; LoadStrobe = 1'b1;
    step();
    for (int t = 1; t <= 2 * FRAME + 1; t++) begin
      LoadStrobe = (t == 5) || (t == 10);
      DataIn = (t == 5) ? 8'h22 : 8'h33;
      step();
      LoadStrobe = 1'b0;
      chk("ovr_line", DataOut, two_frames(8'h11, 8'h22, t));
      if (t == 9) chk("ovr_err_e9", ErrorOut, 1'b0);
      if (t == 10) begin
        chk("ovr_err_e10", ErrorOut, 1'b1);
        chk("ovr_hf_e10", HoldingFull, 1'b1);
      end
      if (t == 2 * FRAME) chk("ovr_err_late", ErrorOut, 1'b1);
      if (t == 2 * FRAME + 1) chk("ovr_busy_end", Busy, 1'b0);
    end

    // Reset during data bit 3 of 0xFF
    DataIn = 8'hFF; LoadStrobe = 1'b1;
    step();
    LoadStrobe = 1'b0;
    for (int t = 1; t <= 70; t++) step();
    chk("rmf_line_before", DataOut, 1'b1);
    chk("rmf_busy_before", Busy, 1'b1);
    Reset = 1'b0;
    #1;
    chk("rmf_line", DataOut, 1'b1);
    chk("rmf_busy", Busy, 1'b0);
    chk("rmf_hf", HoldingFull, 1'b0);
    chk("rmf_irq", HostInterrupt, 1'b0);
    chk("rmf_err", ErrorOut, 1'b0);
    step(); step();
    Reset = 1'b1;
    step();
    DataIn = 8'h0F; LoadStrobe = 1'b1;
    step();
    LoadStrobe = 1'b0;
    for (int t = 1; t <= FRAME + 1; t++) begin
      step();
      chk("rmf_frame_line", DataOut, frame_bit(8'h0F, t));
      if (t == FRAME) chk("rmf_busy_e192", Busy, 1'b1);
      if (t == FRAME + 1) chk("rmf_busy_e193", Busy, 1'b0);
    end
    HostAcknowledge = 1'b1;
    step();
    HostAcknowledge = 1'b0;
    chk("coll_irq_pre", HostInterrupt, 1'b0);

    // Ack held across the transfer edge, plus a load on that same edge
    DataIn = 8'h5A; LoadStrobe = 1'b1;
    step();
    LoadStrobe = 1'b0;
    chk("coll_irq_e0", HostInterrupt, 1'b0);
    for (int t = 1; t <= 2 * FRAME + 1; t++) begin
      LoadStrobe = (t == 1);
      DataIn = 8'hC7;
      HostAcknowledge = (t == 1) || (t == 2);
      step();
      LoadStrobe = 1'b0; HostAcknowledge = 1'b0;
      chk("coll_line", DataOut, two_frames(8'h5A, 8'hC7, t));
      if (t == 1) begin
        chk("coll_irq_e1", HostInterrupt, 1'b1);
        chk("coll_hf_e1", HoldingFull, 1'b1);
        chk("coll_err_e1", ErrorOut, 1'b0);
      end
      if (t == 2) chk("coll_irq_e2", HostInterrupt, 1'b0);
      if (t == FRAME + 1) begin
        chk("coll_irq_e193", HostInterrupt, 1'b1);
        chk("coll_hf_e193", HoldingFull, 1'b0);
      end
      if (t == 2 * FRAME + 1) chk("coll_busy_end", Busy, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
